// File: rtl/cache_fill_pkg.sv
// Shared types and helpers for the multi-channel cache line-fill controller.
package cache_fill_pkg;

  localparam int NUM_STATES = 3;
  localparam int STATE_W    = $clog2(NUM_STATES);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_TAG  = 2'd2
  } fill_state_t;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Index width that stays at least 1 bit wide for single-entry ranges
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cache_fill_arb.sv
// Miss-channel arbiter: fixed priority (highest index wins) or round-robin from rr_ptr upward.
module cache_fill_arb
  import cache_fill_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int PRIO_MODE = PRIO_FIXED,
  parameter int CH_W      = safe_clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic              grant_valid,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  int sel_fix;
  int sel_rr;
  int probe;
  int sel;

  always_comb begin
    sel_fix = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[CH_W'(i)]) sel_fix = i;
    end

    // Walk downward so the candidate closest to rr_ptr is written last
    sel_rr = 0;
    probe  = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      probe = (int'(rr_ptr) + k) % NUM_CH;
      if (req[CH_W'(probe)]) sel_rr = probe;
    end

    sel         = (PRIO_MODE == PRIO_RR) ? sel_rr : sel_fix;
    grant_valid = |req;
    grant       = '0;
    if (grant_valid) grant[CH_W'(sel)] = 1'b1;
    grant_idx   = CH_W'(sel);
  end

endmodule

// File: rtl/cache_fill_ctrl_mc.sv
// Multi-channel cache line-fill controller: arbitrates misses, streams a line of pipelined
// word reads from memory, steers returned words to the owner and finally writes its tag.
module cache_fill_ctrl_mc
  import cache_fill_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 16,
  parameter int LINE_WORDS = 8,
  parameter int WORD_BYTES = 2,
  parameter int PRIO_MODE  = PRIO_FIXED,
  localparam int CH_W      = safe_clog2(NUM_CH),
  localparam int IDX_W     = safe_clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        miss_req,
  input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_data_valid,
  output logic [NUM_CH-1:0]        fsm_data_wen,
  output logic [IDX_W-1:0]         fsm_word_idx,
  output logic [NUM_CH-1:0]        fsm_tag_wen,
  output logic                     busy,
  output logic [CH_W-1:0]          owner
);

  localparam int CNT_W    = IDX_W + 1;
  localparam int OFFSET_W = $clog2(LINE_WORDS * WORD_BYTES);
  localparam int BYTE_SH  = $clog2(WORD_BYTES);

  localparam logic [CNT_W-1:0]  LINE_CNT  = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0]  LAST_RET  = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  fill_state_t         state;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    ret_cnt;
  logic [ADDR_W-1:0]   base_addr;
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     next_rr;

  logic                grant_valid;
  logic [NUM_CH-1:0]   grant;
  logic [CH_W-1:0]     grant_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic                ret_accept;

  cache_fill_arb #(
    .NUM_CH    (NUM_CH),
    .PRIO_MODE (PRIO_MODE),
    .CH_W      (CH_W)
  ) u_arb (
    .req         (miss_req),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_idx   (grant_idx)
  );

  // One-hot AND-OR mux of the granted channel's miss address
  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) sel_addr |= miss_addr[k*ADDR_W +: ADDR_W];
    end
  end

  assign next_rr    = (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;
  assign ret_accept = (state == ST_FILL) && mem_data_valid && (ret_cnt < LINE_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      base_addr <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner     <= grant_idx;
            base_addr <= sel_addr & LINE_MASK;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (issue_cnt < LINE_CNT) issue_cnt <= issue_cnt + 1'b1;
          if (ret_accept) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (ret_cnt == LAST_RET) state <= ST_TAG;
          end
        end
        ST_TAG: begin
          rr_ptr <= next_rr;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word addresses stay inside the aligned line, so the adder never carries past it
  always_comb begin
    mem_rd_en    = (state == ST_FILL) && (issue_cnt < LINE_CNT);
    mem_addr     = mem_rd_en ? (base_addr + (ADDR_W'(issue_cnt) << BYTE_SH)) : '0;
    fsm_data_wen = '0;
    fsm_word_idx = '0;
    fsm_tag_wen  = '0;
    if (ret_accept) begin
      fsm_data_wen[owner] = 1'b1;
      fsm_word_idx        = ret_cnt[IDX_W-1:0];
    end
    if (state == ST_TAG) fsm_tag_wen[owner] = 1'b1;
    busy = (state != ST_IDLE);
  end

endmodule
